// File: rtl/apb_timer_if.sv
// APB bus bundle between the CPU's APB master port and the timer slave.
interface apb_timer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] APB_paddr;
    logic [DATA_WIDTH-1:0] APB_pdata;
    logic [DATA_WIDTH-1:0] APB_prdata;
    logic                  APB_psel;
    logic                  APB_penable;
    logic                  APB_pwrite;
    logic [3:0]            APB_pstb;
    logic                  APB_pready;
    logic                  APB_perr;

    modport master (
        output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        input  APB_prdata, APB_pready, APB_perr
    );

    modport slave (
        input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        output APB_prdata, APB_pready, APB_perr
    );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare match, wrap flag and
// a level interrupt; four word registers with one wait state per transfer.
module apb_timer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rts_n,
    apb_timer_if.slave apb,
    output logic       interrupt
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        XFER_IDLE,
        XFER_ACK
    } xfer_e;

    xfer_e                 state_q, state_d;
    logic                  en_q, en_d;
    logic                  ie_q, ie_d;
    logic                  ar_q, ar_d;
    logic [7:0]            prescale_q, prescale_d;
    logic [7:0]            presc_q, presc_d;
    logic                  pend_q, pend_d;
    logic                  wrap_q, wrap_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  perr_q, perr_d;
    logic                  irq_q, irq_d;

    logic [2:0]            reg_idx;
    logic                  access;
    logic                  wr_commit;
    logic                  tick;
    logic                  match;
    logic                  count_wr;
    logic                  pend_set, wrap_set, pend_clr, wrap_clr;
    logic [DATA_WIDTH-1:0] ctrl_word;
    logic [DATA_WIDTH-1:0] ctrl_new;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_addr;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [3:0]            stb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (stb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    assign reg_idx     = apb.APB_paddr[4:2];
    assign unused_addr = ^{apb.APB_paddr[ADDR_WIDTH-1:5], apb.APB_paddr[1:0]};
    assign access      = apb.APB_psel & apb.APB_penable;
    assign wr_commit   = access & apb.APB_pwrite & (state_q == XFER_ACK);
    assign tick        = en_q & (presc_q == prescale_q);
    assign match       = (count_q == compare_q);
    assign count_wr    = wr_commit & (reg_idx == 3'd2);

    always_comb begin
        ctrl_word       = '0;
        ctrl_word[0]    = en_q;
        ctrl_word[1]    = ie_q;
        ctrl_word[2]    = ar_q;
        ctrl_word[15:8] = prescale_q;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            3'd0:    rd_mux = ctrl_word;
            3'd1:    rd_mux[1:0] = {wrap_q, pend_q};
            3'd2:    rd_mux = count_q;
            3'd3:    rd_mux = compare_q;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d    = XFER_IDLE;
        prdata_d   = prdata_q;
        perr_d     = perr_q;
        en_d       = en_q;
        ie_d       = ie_q;
        ar_d       = ar_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        pend_set   = 1'b0;
        wrap_set   = 1'b0;
        pend_clr   = 1'b0;
        wrap_clr   = 1'b0;
        ctrl_new   = merge_bytes(ctrl_word, apb.APB_pdata, apb.APB_pstb);

        // Data/err are captured on the edge that raises pready, so the
        // master sees a snapshot from the end of the access cycle.
        if (access && state_q == XFER_IDLE) begin
            state_d  = XFER_ACK;
            prdata_d = reg_idx[2] ? '0 : rd_mux;
            perr_d   = reg_idx[2];
        end

        presc_d = (!en_q || tick) ? 8'd0 : presc_q + 8'd1;

        if (tick) begin
            if (match) pend_set = 1'b1;
            if (match && ar_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + DATA_WIDTH'(1);
                if (count_q == '1 && !count_wr) wrap_set = 1'b1;
            end
        end

        if (wr_commit) begin
            case (reg_idx)
                3'd0: begin
                    en_d       = ctrl_new[0];
                    ie_d       = ctrl_new[1];
                    ar_d       = ctrl_new[2];
                    prescale_d = ctrl_new[15:8];
                end
                3'd1: begin
                    pend_clr = apb.APB_pstb[0] & apb.APB_pdata[0];
                    wrap_clr = apb.APB_pstb[0] & apb.APB_pdata[1];
                end
                3'd2:    count_d   = merge_bytes(count_q, apb.APB_pdata, apb.APB_pstb);
                3'd3:    compare_d = merge_bytes(compare_q, apb.APB_pdata, apb.APB_pstb);
                default: ;
            endcase
        end

        pend_d = (pend_q & ~pend_clr) | pend_set;
        wrap_d = (wrap_q & ~wrap_clr) | wrap_set;
        irq_d  = pend_q & ie_q;
    end

    always_ff @(posedge clk or negedge rts_n) begin
        if (!rts_n) begin
            state_q    <= XFER_IDLE;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            ar_q       <= 1'b0;
            prescale_q <= '0;
            presc_q    <= '0;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            count_q    <= '0;
            compare_q  <= '1;
            prdata_q   <= '0;
            perr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            ar_q       <= ar_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
            wrap_q     <= wrap_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prdata_q   <= prdata_d;
            perr_q     <= perr_d;
            irq_q      <= irq_d;
        end
    end

    assign apb.APB_prdata = prdata_q;
    assign apb.APB_pready = (state_q == XFER_ACK);
    assign apb.APB_perr   = perr_q;
    assign interrupt      = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Directed + randomized bench for apb_timer against a cycle-level behavioural model.
module tb_apb_timer;

    logic clk;
    logic rts_n;
    logic interrupt;

    apb_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rts_n     (rts_n),
        .apb       (bus),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit        m_en, m_ie, m_ar;
    bit [7:0]  m_ps;
    int        m_presc;
    bit [31:0] m_count, m_cmp;
    bit        m_pend, m_wrap, m_irq;

    // Write scheduled to commit at the next edge
    bit        w_go;
    bit [2:0]  w_idx;
    bit [31:0] w_data;
    bit [3:0]  w_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] mrg(input bit [31:0] o, input bit [31:0] d, input bit [3:0] s);
        bit [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit [31:0] ctrl_val();
        return {16'h0, m_ps, 5'h0, m_ar, m_ie, m_en};
    endfunction

    function automatic bit [31:0] rd_model(input bit [2:0] idx);
        case (idx)
            3'd0:    return ctrl_val();
            3'd1:    return {30'h0, m_wrap, m_pend};
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_ar = 0; m_ps = 0; m_presc = 0;
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_wrap = 0; m_irq = 0;
        w_go = 0;
    endtask

    // Everything that happens to the timer at one clock edge
    task automatic model_edge();
        bit        tick, hit, cwr;
        bit [31:0] cnt_n, cmp_n, cw;
        bit        pend_n, wrap_n, en_n, ie_n, ar_n;
        bit [7:0]  ps_n;
        int        presc_n;
        tick    = m_en && (m_presc == int'(m_ps));
        presc_n = (!m_en || tick) ? 0 : m_presc + 1;
        cnt_n = m_count; cmp_n = m_cmp; pend_n = m_pend; wrap_n = m_wrap;
        en_n = m_en; ie_n = m_ie; ar_n = m_ar; ps_n = m_ps;
        cwr = w_go && (w_idx == 3'd2);
        if (w_go) begin
            case (w_idx)
                3'd0: begin
                    cw = mrg(ctrl_val(), w_data, w_stb);
                    en_n = cw[0]; ie_n = cw[1]; ar_n = cw[2]; ps_n = cw[15:8];
                end
                3'd1: if (w_stb[0]) begin
                    if (w_data[0]) pend_n = 0;
                    if (w_data[1]) wrap_n = 0;
                end
                3'd2: cnt_n = mrg(m_count, w_data, w_stb);
                3'd3: cmp_n = mrg(m_cmp, w_data, w_stb);
                default: ;
            endcase
        end
        if (tick) begin
            hit = (m_count == m_cmp);
            if (hit) pend_n = 1;
            if (hit && m_ar) begin
                if (!cwr) cnt_n = 0;
            end else if (!cwr) begin
                cnt_n = m_count + 1;
                if (m_count == 32'hFFFF_FFFF) wrap_n = 1;
            end
        end
        m_irq = m_pend && m_ie;
        m_presc = presc_n; m_count = cnt_n; m_cmp = cmp_n; m_pend = pend_n; m_wrap = wrap_n;
        m_en = en_n; m_ie = ie_n; m_ar = ar_n; m_ps = ps_n;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("interrupt", interrupt, m_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic apb(input bit wr, input bit [31:0] addr, input bit [31:0] data,
                       input bit [3:0] stb, output bit [31:0] rd);
        bit [31:0] exp_rd;
        bit        exp_err;
        bus.APB_psel = 1; bus.APB_penable = 0; bus.APB_paddr = addr;
        bus.APB_pwrite = wr; bus.APB_pdata = data; bus.APB_pstb = stb;
        cyc();
        bus.APB_penable = 1;
        chk("pready_T1", bus.APB_pready, 1'b0);
        exp_err = addr[4];
        exp_rd  = exp_err ? 32'h0 : rd_model(addr[4:2]);
        cyc();
        chk("pready_T2", bus.APB_pready, 1'b1);
        chk("perr", bus.APB_perr, exp_err);
        if (!wr) chk($sformatf("prdata@%h", addr[7:0]), bus.APB_prdata, exp_rd);
        rd = bus.APB_prdata;
        w_go = wr; w_idx = addr[4:2]; w_data = data; w_stb = stb;
        cyc();
        w_go = 0;
        bus.APB_psel = 0; bus.APB_penable = 0;
        chk("pready_T3", bus.APB_pready, 1'b0);
    endtask

    task automatic wr32(input bit [31:0] addr, input bit [31:0] data);
        bit [31:0] d;
        apb(1, addr, data, 4'hF, d);
    endtask

    task automatic rd32(input bit [31:0] addr, output bit [31:0] d);
        apb(0, addr, 32'h0, 4'h0, d);
    endtask

    initial begin
        bit [31:0] rd;
        bit [2:0]  idx;
        bit [31:0] data;

        rts_n = 0;
        bus.APB_psel = 0; bus.APB_penable = 0; bus.APB_pwrite = 0;
        bus.APB_paddr = 0; bus.APB_pdata = 0; bus.APB_pstb = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", bus.APB_pready, 1'b0);
        chk("rst_perr", bus.APB_perr, 1'b0);
        chk("rst_prdata", bus.APB_prdata, 32'h0);
        chk("rst_irq", interrupt, 1'b0);
        rts_n = 1;

        rd32(32'h0C, rd);
        chk("rst_compare", rd, 32'hFFFF_FFFF);

        // Prescale 3, compare 5
        wr32(32'h0C, 32'd5);
        wr32(32'h00, 32'h0000_0303);
        for (int i = 0; i < 10; i++) begin
            rd32(32'h08, rd);
            rd32(32'h04, rd);
        end

        // Auto-reload with compare 2, prescale 0
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'h3);
        wr32(32'h08, 32'h0);
        wr32(32'h0C, 32'd2);
        wr32(32'h00, 32'h0000_0007);
        for (int i = 0; i < 6; i++) rd32(32'h08, rd);
        wr32(32'h04, 32'h1);
        idle(2);
        for (int d = 0; d < 6; d++) begin
            idle(d);
            apb(1, 32'h04, 32'h1, 4'h1, rd);
            rd32(32'h04, rd);
        end

        // Wrap from 0xFFFF_FFFE
        wr32(32'h00, 32'h0);
        wr32(32'h0C, 32'h0000_1000);
        wr32(32'h04, 32'h3);
        wr32(32'h08, 32'hFFFF_FFFE);
        wr32(32'h00, 32'h1);
        idle(1);
        rd32(32'h04, rd);
        wr32(32'h08, 32'h10);
        rd32(32'h08, rd);

        // Match at 0xFFFF_FFFF without auto-reload sets PEND and WRAP together
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'h3);
        wr32(32'h0C, 32'hFFFF_FFFF);
        wr32(32'h08, 32'hFFFF_FFFF);
        wr32(32'h00, 32'h1);
        rd32(32'h04, rd);
        chk("match_wrap_status", rd, 32'h3);

        // Byte strobes
        wr32(32'h00, 32'h0);
        wr32(32'h0C, 32'hAABB_CCDD);
        apb(1, 32'h0C, 32'h1122_3344, 4'b0101, rd);
        rd32(32'h0C, rd);
        chk("strobe_compare", rd, 32'hAA22_CC44);

        // Unmapped offsets
        rd32(32'h14, rd);
        wr32(32'h18, 32'hDEAD_BEEF);
        rd32(32'h0C, rd);

        // psel dropped in the access phase: nothing may commit
        bus.APB_psel = 1; bus.APB_penable = 0; bus.APB_pwrite = 1;
        bus.APB_paddr = 32'h0C; bus.APB_pdata = 32'h1234_5678; bus.APB_pstb = 4'hF;
        cyc();
        bus.APB_psel = 0; bus.APB_penable = 1;
        cyc();
        chk("abort_pready_a", bus.APB_pready, 1'b0);
        bus.APB_penable = 0;
        cyc();
        chk("abort_pready_b", bus.APB_pready, 1'b0);
        rd32(32'h0C, rd);

        // Randomized register traffic
        for (int n = 0; n < 80; n++) begin
            idx  = 3'($urandom_range(0, 7));
            data = $urandom;
            case (idx)
                3'd0:    data[15:8] = 8'($urandom_range(0, 3));
                3'd2:    data = $urandom_range(0, 40);
                3'd3:    data = $urandom_range(0, 40);
                default: ;
            endcase
            apb(bit'($urandom_range(0, 1)), {27'h0, idx, 2'b00}, data,
                4'($urandom_range(0, 15)), rd);
            idle($urandom_range(0, 3));
        end

        // Asynchronous reset while pready is high
        wr32(32'h0C, 32'h0000_00A5);
        bus.APB_psel = 1; bus.APB_penable = 0; bus.APB_pwrite = 0;
        bus.APB_paddr = 32'h0C; bus.APB_pstb = 4'h0;
        cyc();
        bus.APB_penable = 1;
        cyc();
        chk("pre_rst_pready", bus.APB_pready, 1'b1);
        chk("pre_rst_prdata", bus.APB_prdata, 32'h0000_00A5);
        #1 rts_n = 0;
        #1;
        chk("arst_pready", bus.APB_pready, 1'b0);
        chk("arst_prdata", bus.APB_prdata, 32'h0);
        chk("arst_perr", bus.APB_perr, 1'b0);
        chk("arst_irq", interrupt, 1'b0);
        model_reset();
        bus.APB_psel = 0; bus.APB_penable = 0;
        #1 rts_n = 1;
        rd32(32'h0C, rd);
        chk("post_rst_compare", rd, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
